roberto_uc: RTL and testbench

Control unit for the ultrasonic-ranging datapath. It sequences one cycle of operation:
- wait one second,
- pulse a measurement on all three sensors,
- wait for the echo window,
- transmit each sensor's 4-character ASCII record (3 digits + '#') over the 7E1 serial transmitter.

It sits directly upstream of the datapath. It drives every zera/cont/medir/partida control input and consumes pronto_seg, pronto_serial, Q_2 and Q_3.

---
 rtl/roberto_uc_pkg.sv | 21 ++
 rtl/roberto_uc_if.sv | 38 +++
 rtl/roberto_uc_contador_m.sv | 31 +++
 rtl/roberto_uc.sv | 118 +++++++++++
 tb/tb_roberto_uc.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/roberto_uc_pkg.sv
// Shared definitions for the ultrasonic-ranging control unit and its datapath:
// state encodings and the record geometry both sides must agree on.
package roberto_pkg;

    // Record geometry: 3 digits + '#' per sensor, three sensors per cycle.
    localparam int DEF_CHARS_PER_SENSOR = 4;
    localparam int DEF_NUM_SENSORS      = 3;

    // Control-unit state encodings (also exported on db_estado).
    localparam logic [3:0] INICIAL        = 4'd0;
    localparam logic [3:0] PREPARACAO     = 4'd1;
    localparam logic [3:0] ESPERA_SEG     = 4'd2;
    localparam logic [3:0] MEDE           = 4'd3;
    localparam logic [3:0] AGUARDA_MEDIDA = 4'd4;
    localparam logic [3:0] TRANSMITE      = 4'd5;
    localparam logic [3:0] ESPERA_TX      = 4'd6;
    localparam logic [3:0] PROXIMO_CHAR   = 4'd7;
    localparam logic [3:0] PROXIMO_SENSOR = 4'd8;
    localparam logic [3:0] FIM            = 4'd9;

endpackage

// File: rtl/roberto_uc_if.sv
// Control/status bundle between the control unit (slave side) and the
// ranging datapath (master side).
interface roberto_uc_if;

    logic       ligar;
    logic       pronto_seg;
    logic       pronto_serial;
    logic [1:0] Q_2;
    logic [1:0] Q_3;

    logic       zera_sensor;
    logic       zera_serial;
    logic       zera_seg;
    logic       zera_2;
    logic       zera_3;
    logic       cont_seg;
    logic       cont_2;
    logic       cont_3;
    logic       medir;
    logic       partida_tx;
    logic       pronto;
    logic [3:0] db_estado;

    // Datapath / environment view: drives status, consumes controls.
    modport master (
        output ligar, pronto_seg, pronto_serial, Q_2, Q_3,
        input  zera_sensor, zera_serial, zera_seg, zera_2, zera_3,
        input  cont_seg, cont_2, cont_3, medir, partida_tx, pronto, db_estado
    );

    // Control-unit view.
    modport slave (
        input  ligar, pronto_seg, pronto_serial, Q_2, Q_3,
        output zera_sensor, zera_serial, zera_seg, zera_2, zera_3,
        output cont_seg, cont_2, cont_3, medir, partida_tx, pronto, db_estado
    );

endinterface

// File: rtl/roberto_uc_contador_m.sv
// Modulo-M wait counter with synchronous clear. It stops at M-1 instead of
// wrapping so a long enable never restarts the interval.
module contador_m #(
    parameter int M = 2_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera_s,
    input  logic conta,
    output logic fim
);

    localparam int W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] LAST = W'(M - 1);

    logic [W-1:0] count_reg;

    assign fim = (count_reg == LAST);

    // Clear has priority; count only while enabled and not yet at the end.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (zera_s) begin
            count_reg <= '0;
        end else if (conta && !fim) begin
            count_reg <= count_reg + W'(1);
        end
    end

endmodule

// File: rtl/roberto_uc.sv
// Control unit of the ultrasonic-ranging system: waits one second, fires a
// measurement on all sensors, waits the echo window, then sends every
// sensor's 4-character record through the serial transmitter.
module roberto_uc
    import roberto_pkg::*;
#(
    parameter int MEDIDA_CICLOS    = 2_000_000,
    parameter int CHARS_PER_SENSOR = DEF_CHARS_PER_SENSOR,
    parameter int NUM_SENSORS      = DEF_NUM_SENSORS
) (
    input  logic         clock,
    input  logic         reset,
    roberto_uc_if.slave  bus
);

    localparam logic [1:0] LAST_CHAR   = 2'(CHARS_PER_SENSOR - 1);
    localparam logic [1:0] LAST_SENSOR = 2'(NUM_SENSORS - 1);

    logic [3:0] estado_reg;
    logic [3:0] estado_next;
    logic       timer_clr;
    logic       timer_en;
    logic       timer_fim;

    // Echo-window timer: restarted before each measurement, runs only while
    // waiting for the echoes.
    assign timer_clr = (estado_reg == PREPARACAO) || (estado_reg == MEDE);
    assign timer_en  = (estado_reg == AGUARDA_MEDIDA);

    contador_m #(
        .M (MEDIDA_CICLOS)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .zera_s (timer_clr),
        .conta  (timer_en),
        .fim    (timer_fim)
    );

    // State register; reset drops straight to inicial.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_reg <= INICIAL;
        end else begin
            estado_reg <= estado_next;
        end
    end

    // Next-state logic; unused encodings recover to inicial.
    always_comb begin
        estado_next = INICIAL;
        case (estado_reg)
            INICIAL:        estado_next = bus.ligar ? PREPARACAO : INICIAL;
            PREPARACAO:     estado_next = ESPERA_SEG;
            ESPERA_SEG:     estado_next = bus.pronto_seg ? MEDE : ESPERA_SEG;
            MEDE:           estado_next = AGUARDA_MEDIDA;
            AGUARDA_MEDIDA: estado_next = timer_fim ? TRANSMITE : AGUARDA_MEDIDA;
            TRANSMITE:      estado_next = ESPERA_TX;
            ESPERA_TX: begin
                if (!bus.pronto_serial) begin
                    estado_next = ESPERA_TX;
                end else if (bus.Q_2 != LAST_CHAR) begin
                    estado_next = PROXIMO_CHAR;
                end else if (bus.Q_3 != LAST_SENSOR) begin
                    estado_next = PROXIMO_SENSOR;
                end else begin
                    estado_next = FIM;
                end
            end
            PROXIMO_CHAR:   estado_next = TRANSMITE;
            PROXIMO_SENSOR: estado_next = TRANSMITE;
            FIM:            estado_next = bus.ligar ? ESPERA_SEG : INICIAL;
            default:        estado_next = INICIAL;
        endcase
    end

    // Moore output decode. fim always clears the indices so a continued
    // cycle restarts at sensor 0, char 0.
    always_comb begin
        bus.zera_sensor = 1'b0;
        bus.zera_serial = 1'b0;
        bus.zera_seg    = 1'b0;
        bus.zera_2      = 1'b0;
        bus.zera_3      = 1'b0;
        bus.cont_seg    = 1'b0;
        bus.cont_2      = 1'b0;
        bus.cont_3      = 1'b0;
        bus.medir       = 1'b0;
        bus.partida_tx  = 1'b0;
        bus.pronto      = 1'b0;
        bus.db_estado   = estado_reg;
        case (estado_reg)
            PREPARACAO: begin
                bus.zera_sensor = 1'b1;
                bus.zera_serial = 1'b1;
                bus.zera_seg    = 1'b1;
                bus.zera_2      = 1'b1;
                bus.zera_3      = 1'b1;
            end
            ESPERA_SEG:     bus.cont_seg   = 1'b1;
            MEDE:           bus.medir      = 1'b1;
            TRANSMITE:      bus.partida_tx = 1'b1;
            PROXIMO_CHAR:   bus.cont_2     = 1'b1;
            PROXIMO_SENSOR: begin
                bus.cont_3 = 1'b1;
                bus.zera_2 = 1'b1;
            end
            FIM: begin
                bus.pronto   = 1'b1;
                bus.zera_seg = 1'b1;
                bus.zera_2   = 1'b1;
                bus.zera_3   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_roberto_uc.sv
// Bench for roberto_uc with a short echo window. Models the datapath index
// counters, the one-second counter and a transmitter that answers 5 cycles
// after each start, and predicts the control sequence from a script of the
// operating cycle.
module tb_roberto_uc;
    import roberto_pkg::*;

    localparam int M = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;

    roberto_uc_if bus();

    roberto_uc #(
        .MEDIDA_CICLOS (M)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(string name, int act, int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- datapath / environment model ----------------
    logic       ligar_drv  = 1'b0;
    logic       spur       = 1'b0;
    logic [1:0] q2         = 2'd0;
    logic [1:0] q3         = 2'd0;
    int         seg_cnt    = 0;
    int         seg_target = 2;
    logic [4:0] tx_sh      = 5'd0;

    assign bus.ligar         = ligar_drv;
    assign bus.Q_2           = q2;
    assign bus.Q_3           = q3;
    assign bus.pronto_seg    = (seg_cnt == seg_target);
    assign bus.pronto_serial = tx_sh[4] | spur;

    always @(posedge clock) begin
        if (bus.zera_2) q2 <= 2'd0;
        else if (bus.cont_2) q2 <= q2 + 2'd1;
        if (bus.zera_3) q3 <= 2'd0;
        else if (bus.cont_3) q3 <= q3 + 2'd1;
        if (bus.zera_seg) begin
            seg_cnt    <= 0;
            seg_target <= int'($urandom_range(0, 6));
        end else if (bus.cont_seg) begin
            seg_cnt <= seg_cnt + 1;
        end
        tx_sh <= {tx_sh[3:0], bus.partida_tx};
    end

    // ---------------- behavioural reference ----------------
    // Output vector order: zera_sensor zera_serial zera_seg zera_2 zera_3
    //                      cont_seg cont_2 cont_3 medir partida_tx pronto
    function automatic logic [10:0] outs_for(int ph);
        case (ph)
            1:       return 11'b11111000000;
            2:       return 11'b00000100000;
            3:       return 11'b00000000100;
            5:       return 11'b00000000010;
            7:       return 11'b00000010000;
            8:       return 11'b00010001000;
            9:       return 11'b00111000001;
            default: return 11'b00000000000;
        endcase
    endfunction

    function automatic logic [10:0] dut_outs();
        return {bus.zera_sensor, bus.zera_serial, bus.zera_seg, bus.zera_2, bus.zera_3,
                bus.cont_seg, bus.cont_2, bus.cont_3, bus.medir, bus.partida_tx, bus.pronto};
    endfunction

    logic [10:0] exp_o    = '0;
    logic [3:0]  exp_db   = '0;
    logic        exp_qv   = 1'b0;
    logic [1:0]  exp_q2   = 2'd0;
    logic [1:0]  exp_q3   = 2'd0;
    logic        model_en = 1'b0;
    bit          s_ligar, s_pseg, s_pser;

    task automatic expect_phase(int ph);
        exp_db = 4'(ph);
        exp_o  = outs_for(ph);
        exp_qv = 1'b0;
        spur   = 1'b0;
    endtask

    // Sample inputs exactly as the DUT sees them at the edge, then move on.
    task automatic adv();
        @(posedge clock);
        s_ligar = bus.ligar;
        s_pseg  = bus.pronto_seg;
        s_pser  = bus.pronto_serial;
        #1;
    endtask

    task automatic run_cycle();
        do begin
            expect_phase(2);
            spur = ($urandom_range(0, 3) == 0);
            adv();
        end while (!s_pseg);
        expect_phase(3);
        adv();
        repeat (M) begin
            expect_phase(4);
            spur = ($urandom_range(0, 2) == 0);
            adv();
        end
        for (int s = 0; s < DEF_NUM_SENSORS; s++) begin
            for (int c = 0; c < DEF_CHARS_PER_SENSOR; c++) begin
                expect_phase(5);
                exp_qv = 1'b1;
                exp_q2 = 2'(c);
                exp_q3 = 2'(s);
                adv();
                do begin
                    expect_phase(6);
                    adv();
                end while (!s_pser);
                if (c != DEF_CHARS_PER_SENSOR - 1) begin
                    expect_phase(7);
                    adv();
                end else if (s != DEF_NUM_SENSORS - 1) begin
                    expect_phase(8);
                    adv();
                end
            end
        end
        expect_phase(9);
        adv();
    endtask

    initial begin : model
        wait (reset === 1'b1);
        forever begin
            expect_phase(0);
            do adv(); while (!s_ligar);
            expect_phase(1);
            adv();
            do run_cycle(); while (s_ligar);
        end
    end

    // Per-cycle comparison against the reference.
    always @(negedge clock) begin
        if (model_en) begin
            check("outputs", int'(dut_outs()), int'(exp_o));
            check("db_estado", int'(bus.db_estado), int'(exp_db));
            if (exp_qv) check("index_at_partida", int'({bus.Q_3, bus.Q_2}), int'({exp_q3, exp_q2}));
        end
    end

    // Transaction monitor with hand-computed pins on the model.
    int cyc = 0, medir_cyc = 0, partida_total = 0, partida_since = 0, pronto_total = 0;
    bit after_medir = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (model_en) begin
            if (bus.medir) begin
                medir_cyc   = cyc;
                after_medir = 1'b1;
            end
            if (bus.partida_tx) begin
                partida_total++;
                partida_since++;
                $display("tx %0d: sensor %0d char %0d at cycle %0d", partida_total, bus.Q_3, bus.Q_2, cyc);
                if (after_medir) begin
                    check("medir_to_partida_latency", cyc - medir_cyc, 9);
                    after_medir = 1'b0;
                end
            end
            if (bus.pronto) begin
                pronto_total++;
                $display("cycle done %0d at cycle %0d", pronto_total, cyc);
                check("partidas_per_cycle", partida_since, 12);
                partida_since = 0;
            end
        end
    end

    task automatic wait_partidas(int n, string name);
        int budget = 3000;
        while (partida_total < n && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        check(name, int'(partida_total >= n), 1);
    endtask

    task automatic wait_prontos(int n, string name);
        int budget = 3000;
        while (pronto_total < n && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        check(name, int'(pronto_total >= n), 1);
    endtask

    initial begin : main
        reset     = 1'b0;
        ligar_drv = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("reset_db_estado", int'(bus.db_estado), 0);
            check("reset_outputs", int'(dut_outs()), 0);
        end
        reset    = 1'b1;
        model_en = 1'b1;
        @(negedge clock);
        check("release_preparacao", int'(bus.db_estado), 1);
        @(negedge clock);
        check("release_espera_seg", int'(bus.db_estado), 2);

        // Two complete cycles with ligar held, then drop it on the 5th char of the third.
        wait_partidas(29, "reach_5th_tx_of_cycle3");
        check("cycles_done_before_drop", pronto_total, 2);
        ligar_drv = 1'b0;
        wait_prontos(3, "cycle3_completes");
        check("total_partidas_after_drop", partida_total, 36);
        @(negedge clock);
        repeat (20) begin
            @(negedge clock);
            check("idle_after_drop", int'(bus.db_estado), 0);
        end

        // Restart, then hit reset asynchronously while waiting on the transmitter.
        ligar_drv = 1'b1;
        wait_partidas(39, "reach_3rd_tx_of_cycle4");
        begin
            int budget = 20;
            while (bus.db_estado != 4'd6 && budget > 0) begin
                @(negedge clock);
                budget--;
            end
            check("reach_espera_tx", int'(bus.db_estado), 6);
        end
        @(posedge clock);
        #2;
        model_en = 1'b0;
        reset    = 1'b0;
        #1;
        check("async_reset_db_estado", int'(bus.db_estado), 0);
        check("async_reset_outputs", int'(dut_outs()), 0);
        repeat (3) begin
            @(negedge clock);
            check("held_reset_db_estado", int'(bus.db_estado), 0);
            check("held_reset_outputs", int'(dut_outs()), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        miscompares++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

endmodule
